// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: trit codes, FSM state encodings and trit helpers for the ternary core sequencer
package cpu_sequencer_pkg;
  localparam logic [1:0] T_0 = 2'b00;
  localparam logic [1:0] T_P = 2'b01;
  localparam logic [1:0] T_N = 2'b10;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_MEM    = 4'd4;
  localparam logic [3:0] S_WB     = 4'd5;
  localparam logic [3:0] S_NEXT   = 4'd6;
  localparam logic [3:0] S_HALT   = 4'd7;
  localparam logic [3:0] S_FAULT  = 4'd8;
  // The unused code 2'b11 decodes as zero.
  function automatic logic signed [3:0] trit_val(input logic [1:0] t);
    return t == T_P ? 4'sd1 : t == T_N ? -4'sd1 : 4'sd0;
  endfunction
  function automatic logic [1:0] trit_enc(input logic signed [3:0] v);
    return v > 4'sd0 ? T_P : v < 4'sd0 ? T_N : T_0;
  endfunction
endpackage

// File: rtl/cpu_sequencer_trit_adder.sv
// trit_adder: N-trit balanced-ternary ripple adder, carry out discarded (wraps modulo 3^N)
//   a_i, b_i : 2N-bit trit-encoded operands
//   sum_o    : 2N-bit trit-encoded sum
module trit_adder import cpu_sequencer_pkg::*; #(
  parameter int N = 9
) (
  input  logic [2*N-1:0] a_i,
  input  logic [2*N-1:0] b_i,
  output logic [2*N-1:0] sum_o
);
  logic signed [3:0] c [N];
  assign c[0] = 4'sd0;
  for (genvar i = 0; i < N; i++) begin : g_trit
    logic signed [3:0] s;
    assign s = trit_val(a_i[2*i+:2]) + trit_val(b_i[2*i+:2]) + c[i];
    assign sum_o[2*i+:2] = trit_enc(s > 4'sd1 ? s - 4'sd3 : s < -4'sd1 ? s + 4'sd3 : s);
    if (i < N - 1) begin : g_carry
      assign c[i+1] = s > 4'sd1 ? 4'sd1 : s < -4'sd1 ? -4'sd1 : 4'sd0;
    end
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FSM, ternary PC and instruction register with memory handshake and timeout
//   clock/reset            : clock, synchronous active-high reset
//   execute/step_mode      : start on rising edge; step_mode stops after each instruction
//   op_*                   : decoder flags for the latched ir
//   branch_taken/offset    : relative branch applied in NEXT
//   data_addr              : load/store address
//   mem_ready/read_data    : memory completion and read data
//   mem_address/req/we     : memory request bus
//   ir, pc, state          : architectural and debug state
//   do_*                   : one-cycle datapath strobes
//   halted, fault          : sticky status
module cpu_sequencer import cpu_sequencer_pkg::*; #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 9,
  parameter int WAIT_LIMIT    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       execute,
  input  logic                       step_mode,
  input  logic                       op_alu,
  input  logic                       op_load,
  input  logic                       op_store,
  input  logic                       op_halt,
  input  logic                       op_wb,
  input  logic                       branch_taken,
  input  logic [2*MEM_ADDR_SIZE-1:0] branch_offset,
  input  logic [2*MEM_ADDR_SIZE-1:0] data_addr,
  input  logic                       mem_ready,
  input  logic [2*WORD_SIZE-1:0]     mem_read_data,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_address,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [2*WORD_SIZE-1:0]     ir,
  output logic [2*MEM_ADDR_SIZE-1:0] pc,
  output logic                       do_reg_load,
  output logic                       do_alu,
  output logic                       do_reg_store,
  output logic                       do_next,
  output logic                       halted,
  output logic                       fault,
  output logic [3:0]                 state
);
  localparam int AW = 2 * MEM_ADDR_SIZE;
  localparam int CW = $clog2(WAIT_LIMIT + 2);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT > 0 ? WAIT_LIMIT - 1 : 0);
  localparam logic [AW-1:0] PC_ONE = AW'(T_P);
  logic [3:0] state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_sum;
  logic [2*WORD_SIZE-1:0] ir_q, ir_d;
  logic [CW-1:0] wait_q, wait_d;
  logic exec_q, exec_rise, timeout;
  trit_adder #(.N(MEM_ADDR_SIZE)) u_pc_add (
    .a_i  (pc_q),
    .b_i  (branch_taken ? branch_offset : PC_ONE),
    .sum_o(pc_sum)
  );
  assign exec_rise    = execute && !exec_q;
  assign mem_req      = state_q == S_FETCH || state_q == S_MEM;
  assign mem_we       = state_q == S_MEM && op_store;
  assign mem_address  = state_q == S_MEM ? data_addr : pc_q;
  assign do_reg_load  = state_q == S_DECODE;
  assign do_alu       = state_q == S_EXEC;
  assign do_reg_store = state_q == S_WB;
  assign do_next      = state_q == S_NEXT;
  assign halted       = state_q == S_HALT;
  assign fault        = state_q == S_FAULT;
  assign state        = state_q;
  assign pc           = pc_q;
  assign ir           = ir_q;
  // A ready on the limit cycle is checked first, so it wins over the timeout.
  assign timeout = (WAIT_LIMIT > 0) && wait_q == WAIT_LAST;
  // Only FETCH and MEM request, and they are never adjacent, so leaving them clears the counter.
  assign wait_d  = mem_req && !mem_ready ? wait_q + 1'b1 : '0;
  assign pc_d    = state_q == S_NEXT ? pc_sum : pc_q;
  assign ir_d    = state_q == S_FETCH && mem_ready ? mem_read_data : ir_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = exec_rise ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      S_DECODE: state_d = op_halt ? S_HALT : op_alu ? S_EXEC : (op_load || op_store) ? S_MEM :
                          op_wb ? S_WB : S_NEXT;
      S_EXEC:   state_d = S_WB;
      S_MEM:    state_d = mem_ready ? (op_store ? S_NEXT : S_WB) : timeout ? S_FAULT : S_MEM;
      S_WB:     state_d = S_NEXT;
      S_NEXT:   state_d = step_mode ? S_IDLE : S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    exec_q <= execute;
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table, hand-written and random checks of cpu_sequencer against a trit-arithmetic model
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;
  localparam int HALF = 9841;
  localparam int MODV = 19683;
  logic clock = 1'b0;
  logic reset, execute, step_mode, op_alu, op_load, op_store, op_halt, op_wb, branch_taken, mem_ready;
  logic [17:0] branch_offset, data_addr, mem_read_data, mem_address, ir, pc;
  logic mem_req, mem_we, do_reg_load, do_alu, do_reg_store, do_next, halted, fault;
  logic [3:0] state;
  int n_cmp = 0;
  int n_bad = 0;
  int pc_m;
  logic [17:0] ir_m;

  cpu_sequencer #(.WORD_SIZE(9), .MEM_ADDR_SIZE(9), .WAIT_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .execute(execute), .step_mode(step_mode),
    .op_alu(op_alu), .op_load(op_load), .op_store(op_store), .op_halt(op_halt), .op_wb(op_wb),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .data_addr(data_addr),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data), .mem_address(mem_address),
    .mem_req(mem_req), .mem_we(mem_we), .ir(ir), .pc(pc), .do_reg_load(do_reg_load),
    .do_alu(do_alu), .do_reg_store(do_reg_store), .do_next(do_next), .halted(halted),
    .fault(fault), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int kind;
    int fw;
    int mw;
    bit tk;
    int off;
    int cyc;
    int pc;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] to_tern(input int v);
    logic [17:0] r;
    int x, d;
    r = '0;
    x = v;
    for (int i = 0; i < 9; i++) begin
      d = ((x % 3) + 3) % 3;
      if (d == 2) d = -1;
      r[2*i+:2] = d == 1 ? T_P : d == -1 ? T_N : T_0;
      x = (x - d) / 3;
    end
    return r;
  endfunction

  function automatic int wrapv(input int v);
    int x;
    x = v;
    while (x > HALF) x -= MODV;
    while (x < -HALF) x += MODV;
    return x;
  endfunction

  // kind: 0 none, 1 alu, 2 load, 3 store, 4 write-back only
  function automatic int model_cycles(input int kind, input int fw, input int mw);
    return fw + 3 + (kind == 1 ? 2 : kind == 2 ? mw + 2 : kind == 3 ? mw + 1 : kind == 4 ? 1 : 0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pc_m = 0;
    ir_m = '0;
  endtask

  task automatic start();
    @(negedge clock);
    execute = 1'b1;
    @(posedge clock);
    #1;
    execute = 1'b0;
  endtask

  // Runs one instruction starting in the first FETCH cycle; ends one tick after the NEXT edge.
  task automatic run_instr(input int kind, input int fw, input int mw, input bit tk, input int off,
                           input int exp_cyc, input int exp_pc);
    logic [17:0] oe, da, rd;
    int cyc, rq, nl, na, ns;
    bit done, xw;
    oe = to_tern(off);
    for (int i = 0; i < 9; i++)
      if (oe[2*i+:2] == T_0 && $urandom_range(0, 3) == 0) oe[2*i+:2] = 2'b11;
    da = 18'($urandom);
    rd = 18'($urandom);
    xw = $urandom_range(0, 1) == 1 && kind >= 1 && kind <= 3;
    op_alu = kind == 1;
    op_load = kind == 2;
    op_store = kind == 3;
    op_wb = kind == 4 || xw;
    op_halt = 1'b0;
    branch_taken = tk;
    branch_offset = oe;
    data_addr = da;
    mem_read_data = rd;
    cyc = 0; rq = 0; nl = 0; na = 0; ns = 0; done = 0;
    while (!done && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (mem_req) begin
        if (rq <= fw) begin
          chk("fetch_bus", {mem_we, mem_address}, {1'b0, to_tern(pc_m)});
          chk("ir_hold", ir, ir_m);
        end else chk("mem_bus", {mem_we, mem_address}, {kind == 3, da});
        mem_ready = rq == fw || ((kind == 2 || kind == 3) && rq == fw + 1 + mw);
        rq++;
      end else mem_ready = 1'b0;
      nl += int'(do_reg_load);
      na += int'(do_alu);
      ns += int'(do_reg_store);
      if (do_next) begin
        done = 1;
        chk("ir_latch", ir, rd);
      end
    end
    chk("instr_done", done, 1);
    chk("cycles", cyc, exp_cyc);
    chk("strobes", na * 100 + ns * 10 + nl,
        int'(kind == 1) * 100 + int'(kind == 1 || kind == 2 || kind == 4) * 10 + 1);
    chk("req_cycles", rq, fw + 1 + ((kind == 2 || kind == 3) ? mw + 1 : 0));
    @(posedge clock);
    #1;
    mem_ready = 1'b0;
    pc_m = exp_pc;
    ir_m = rd;
    chk("pc", pc, to_tern(pc_m));
  endtask

  initial begin
    int exp_st[4] = '{1, 2, 6, 1};
    int exp_nx[4] = '{0, 0, 1, 0};
    int exp_pc[4] = '{0, 0, 0, 1};
    int n;
    bit hit;
    {execute, step_mode, op_alu, op_load, op_store, op_halt, op_wb, branch_taken, mem_ready} = '0;
    branch_offset = '0;
    data_addr = '0;
    mem_read_data = '0;
    // Reset state, with execute held high to show a level alone does not start.
    execute = 1'b1;
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_outs", {do_reg_load, do_alu, do_reg_store, do_next, mem_req, mem_we, halted, fault}, 0);
    repeat (3) @(negedge clock);
    chk("level_exec", state, 0);
    execute = 1'b0;
    // State trace of a flagless instruction with zero-wait memory.
    do_reset();
    mem_ready = 1'b1;
    @(negedge clock);
    chk("trace_idle", state, 0);
    execute = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("trace_state", state, exp_st[i]);
      chk("trace_next", do_next, exp_nx[i]);
      chk("trace_pc", pc, to_tern(exp_pc[i]));
    end
    execute = 1'b0;
    mem_ready = 1'b0;
    // Directed instruction table, including branch, wrap and ready-on-limit.
    tbl[0] = '{0, 0, 0, 1'b0, 0, 3, 1};
    tbl[1] = '{1, 0, 0, 1'b1, 4, 5, 5};
    tbl[2] = '{0, 0, 0, 1'b1, -2, 3, 3};
    tbl[3] = '{2, 1, 2, 1'b0, 0, 8, 4};
    tbl[4] = '{3, 0, 0, 1'b1, 9837, 4, 9841};
    tbl[5] = '{4, 2, 0, 1'b0, 0, 6, -9841};
    tbl[6] = '{0, 3, 0, 1'b0, 0, 6, -9840};
    do_reset();
    start();
    for (int i = 0; i < 7; i++)
      run_instr(tbl[i].kind, tbl[i].fw, tbl[i].mw, tbl[i].tk, tbl[i].off, tbl[i].cyc, tbl[i].pc);
    // Random instruction stream against the model.
    for (int k = 0; k < 40; k++) begin
      int kd, f, m, o;
      bit t;
      kd = $urandom_range(0, 4);
      f = $urandom_range(0, 3);
      m = $urandom_range(0, 3);
      t = $urandom_range(0, 1) == 1;
      o = int'($urandom_range(0, MODV - 1)) - HALF;
      run_instr(kd, f, m, t, o, model_cycles(kd, f, m), wrapv(pc_m + (t ? o : 1)));
    end
    // Reset while a load waits in MEM.
    {op_alu, op_store, op_wb, op_halt, branch_taken} = '0;
    op_load = 1'b1;
    mem_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clock);
      hit = state == 4;
    end
    chk("reach_mem", hit, 1);
    chk("mem_req_in_mem", mem_req, 1);
    mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_state", state, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_req", mem_req, 0);
    op_load = 1'b0;
    // Fetch timeout with WAIT_LIMIT=4.
    do_reset();
    start();
    n = 0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      hit = state == 8;
      if (!hit && mem_req) n++;
    end
    chk("timeout_reqs", n, 4);
    chk("fault_state", {fault, halted, mem_req}, 3'b100);
    @(negedge clock);
    execute = 1'b1;
    repeat (3) @(negedge clock);
    chk("fault_sticky", {state, fault}, {4'd8, 1'b1});
    execute = 1'b0;
    // Single-step with execute held high.
    do_reset();
    step_mode = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    execute = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      hit = do_next;
    end
    chk("step_next", hit, 1);
    @(negedge clock);
    chk("step_idle", state, 0);
    repeat (3) @(negedge clock);
    chk("step_hold", state, 0);
    chk("step_pc", pc, to_tern(1));
    execute = 1'b0;
    @(negedge clock);
    execute = 1'b1;
    @(negedge clock);
    chk("step_rerun", state, 1);
    execute = 1'b0;
    step_mode = 1'b0;
    // Halt has priority over the ALU flag and is sticky.
    do_reset();
    op_halt = 1'b1;
    op_alu = 1'b1;
    start();
    n = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clock);
      n += int'(do_alu);
      hit = state == 7;
    end
    chk("halt_reach", hit, 1);
    chk("halt_no_alu", n, 0);
    chk("halt_outs", {halted, fault, mem_req}, 3'b100);
    @(negedge clock);
    execute = 1'b1;
    repeat (3) @(negedge clock);
    chk("halt_sticky", {state, halted}, {4'd7, 1'b1});
    execute = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
